// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// The FSM state is exported so checkers and benches can observe it directly.
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          QDEPTH_DEFAULT   = 2;
    localparam int          ENTRY_W          = 64;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_queue.sv
// Small FIFO of {pc, inst} entries. Entry 0 is always the head, so the head is a plain
// register and keeps its last value when the queue drains or is flushed.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEFAULT,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] head,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               do_push;
    logic               do_pop;
    logic [CW-1:0]      wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign wr_idx  = do_pop ? count - 1'b1 : count;
    assign head    = mem[0];

    // Entries shift toward the head on pop; the last live entry is never shifted out,
    // so a pop that empties the queue leaves the head value untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (CW'(i + 1) < count) begin
                        mem[i] <= mem[i + 1];
                    end
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (wr_idx == CW'(i))) begin
                    mem[i] <= din;
                end
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request feeding a small queue to the
// decoder, with decoder-driven redirects that flush the queue and drain stale responses.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_ce,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        jCe,
    input  logic [31:0] jAddr,
    output ifu_state_t  state_dbg
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    // Handshakes: the decoder consumes the head on a cycle with inst_valid & inst_ready;
    // a memory request is live while imem_ce=1 and completes on the cycle imem_ack=1.
    ifu_state_t   state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic [31:0]  tgt_pc, tgt_pc_nxt;
    logic         redirect;
    logic         q_push, q_pop, q_full, q_empty;
    logic [CW-1:0] q_count;
    logic [CW:0]  occ_after;
    logic [ENTRY_W-1:0] q_head;

    assign redirect  = jCe & inst_valid & inst_ready;
    assign q_pop     = inst_ready;
    assign q_push    = imem_ack & (state == ST_REQ) & ~redirect & ~q_full;
    assign occ_after = {1'b0, q_count} + (CW + 1)'(q_push) - (CW + 1)'(q_pop & ~q_empty);

    assign imem_ce    = (state == ST_REQ) | (state == ST_DRAIN);
    assign imem_addr  = fetch_pc;
    assign inst_valid = ~q_empty;
    assign pc         = q_head[63:32];
    assign inst       = q_head[31:0];
    assign state_dbg  = state;

    ifu_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .din   ({fetch_pc, imem_rdata}),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            tgt_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            tgt_pc   <= tgt_pc_nxt;
        end
    end

    // fetch_pc is the address of the live request (or the next one to issue); during
    // DRAIN it still holds the stale address and the redirect target waits in tgt_pc.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        tgt_pc_nxt   = tgt_pc;
        unique case (state)
            // IDLE ignores any ack, which drops a response left over from before reset.
            ST_IDLE: begin
                if (occ_after < QD) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_nxt = word_align(jAddr);
                        state_nxt    = ST_REQ;
                    end else begin
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = (occ_after < QD) ? ST_REQ : ST_FULL;
                    end
                end else if (redirect) begin
                    tgt_pc_nxt = word_align(jAddr);
                    state_nxt  = ST_DRAIN;
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    fetch_pc_nxt = word_align(jAddr);
                    state_nxt    = ST_REQ;
                end else if (inst_valid & inst_ready) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    tgt_pc_nxt = word_align(jAddr);
                end
                if (imem_ack) begin
                    fetch_pc_nxt = redirect ? word_align(jAddr) : tgt_pc;
                    state_nxt    = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: a latency-configurable memory responder and a decoder driver, with an
// expected-pc stream model (next pc = pc+4, or the word-aligned target on an accepted jump).
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ce;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst, pc;
  logic        jCe = 1'b0;
  logic [31:0] jAddr = '0;
  ifu_state_t  state_dbg;

  logic        ce2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] inst2, pc2;
  logic        jce2 = 1'b0;
  logic [31:0] jaddr2 = '0;
  ifu_state_t  state2;

  int total = 0;
  int bad = 0;
  int mem_lat = 0;
  int mem_lat_cur = 0;
  int mem_wait = 0;
  bit mem_rand = 1'b0;
  logic [31:0] exp_pc;

  ifu dut (
    .clk(clk), .rst(rst), .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .pc(pc), .jCe(jCe), .jAddr(jAddr), .state_dbg(state_dbg)
  );

  ifu #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_ce(ce2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .inst_valid(valid2), .inst_ready(ready2), .inst(inst2),
    .pc(pc2), .jCe(jce2), .jAddr(jaddr2), .state_dbg(state2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One cycle: advance to the falling edge and drive both memory responders.
  task automatic tick();
    @(negedge clk);
    imem_ack = 1'b0;
    if (imem_ce && !rst) begin
      if (mem_wait >= mem_lat_cur) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_wait = 0;
        mem_lat_cur = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        mem_wait++;
      end
    end
    ack2 = ce2 & ~rst;
    rdata2 = mem_word(addr2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    jCe = 1'b0;
    jAddr = '0;
    repeat (3) @(negedge clk);
    mem_wait = 0;
    mem_lat_cur = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    jCe = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", inst); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
    total++; if (imem_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", imem_ce); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    total++; if (addr2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_addr_wrapdut: got %h want fffffff8", addr2); end
    total++; if (ce2 !== 1'b0) begin bad++; $display("FAIL reset_ce_wrapdut: got %b want 0", ce2); end
    mem_lat = 0; mem_rand = 1'b0; mem_wait = 0; mem_lat_cur = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (imem_ce !== 1'b1) begin bad++; $display("FAIL first_ce: got %b want 1", imem_ce); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    int got;
    int first_c;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    exp_pc = 32'h0;
    got = 0;
    first_c = -1;
    for (int c = 0; c < 30 && got < 12; c++) begin
      tick();
      if (inst_valid === 1'b1 && first_c < 0) first_c = c;
      if (first_c >= 0) begin
        total++;
        if (inst_valid !== 1'b1) begin
          bad++; $display("FAIL stream_bubble: cycle %0d valid %b want 1", c, inst_valid);
        end else begin
          total++; if (pc !== exp_pc) begin bad++; $display("FAIL stream_pc: got %h want %h", pc, exp_pc); end
          total++; if (inst !== mem_word(exp_pc)) begin bad++; $display("FAIL stream_inst: got %h want %h", inst, mem_word(exp_pc)); end
          exp_pc += 32'd4;
          got++;
        end
      end
    end
    total++; if (first_c != 1) begin bad++; $display("FAIL stream_latency: first valid at cycle %0d want 1", first_c); end
    total++; if (got != 12) begin bad++; $display("FAIL stream_count: got %0d want 12", got); end
  endtask

  task automatic test_backpressure();
    int acks;
    int got;
    bit addr_chk;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset();
    acks = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (imem_ack) acks++;
      if (c >= 3) begin
        total++; if (imem_ce !== 1'b0) begin bad++; $display("FAIL bp_ce_while_full: cycle %0d got %b want 0", c, imem_ce); end
      end
    end
    total++; if (acks != 2) begin bad++; $display("FAIL bp_fetch_count: got %0d want 2", acks); end
    total++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL bp_head: valid %b pc %h want 1 0", inst_valid, pc); end
    total++; if (state_dbg !== ST_FULL) begin bad++; $display("FAIL bp_state: got %0d want %0d", state_dbg, ST_FULL); end
    exp_pc = 32'h0;
    got = 0;
    addr_chk = 1'b0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      tick();
      inst_ready = 1'b1;
      if (imem_ce === 1'b1 && !addr_chk) begin
        addr_chk = 1'b1;
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_resume_addr: got %h want 8", imem_addr); end
      end
      if (inst_valid === 1'b1) begin
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL bp_pc: got %h want %h", pc, exp_pc); end
        exp_pc += 32'd4;
        got++;
      end
    end
    total++; if (got != 3 || !addr_chk) begin bad++; $display("FAIL bp_resume: got %0d pcs fetch %b want 3 1", got, addr_chk); end
  endtask

  task automatic test_redirect_drain();
    bit redirected, saw_ack8, addr_chk, done;
    int rc;
    mem_lat = 3; mem_rand = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    exp_pc = 32'h0;
    redirected = 1'b0; saw_ack8 = 1'b0; addr_chk = 1'b0; done = 1'b0;
    rc = -10;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      jCe = 1'b0;
      if (c == rc + 1) begin
        total++; if (state_dbg !== ST_DRAIN) begin bad++; $display("FAIL drain_state: got %0d want %0d", state_dbg, ST_DRAIN); end
        total++; if (imem_ce !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL drain_hold: ce %b addr %h want 1 8", imem_ce, imem_addr); end
      end
      if (saw_ack8 && !addr_chk && imem_ce === 1'b1) begin
        addr_chk = 1'b1;
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL drain_next_addr: got %h want 100", imem_addr); end
      end
      if (redirected && imem_ack && imem_addr === 32'h8) saw_ack8 = 1'b1;
      if (inst_valid === 1'b1) begin
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL drain_pc: got %h want %h", pc, exp_pc); end
        total++; if (inst !== mem_word(exp_pc)) begin bad++; $display("FAIL drain_inst: got %h want %h", inst, mem_word(exp_pc)); end
        if (exp_pc == 32'h100) done = 1'b1;
        if (exp_pc == 32'h4 && !redirected) begin
          total++; if (imem_ce !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL drain_outstanding: ce %b addr %h want 1 8", imem_ce, imem_addr); end
          jCe = 1'b1; jAddr = 32'h0000_0100;
          redirected = 1'b1; rc = c;
          exp_pc = 32'h100;
        end else begin
          exp_pc += 32'd4;
        end
      end
    end
    total++; if (!done || !addr_chk) begin bad++; $display("FAIL drain_reach_target: reached %b fetched %b want 1 1", done, addr_chk); end
  endtask

  task automatic test_redirect_ack();
    bit redirected, done;
    int rc;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    exp_pc = 32'h0;
    redirected = 1'b0; done = 1'b0;
    rc = -10;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      jCe = 1'b0;
      if (c == rc + 1) begin
        total++; if (imem_ce !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL jack_next_req: ce %b addr %h want 1 200", imem_ce, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL jack_flushed: valid %b want 0", inst_valid); end
        total++; if (pc !== 32'h8 || inst !== mem_word(32'h8)) begin bad++; $display("FAIL jack_hold: pc %h inst %h want 8 %h", pc, inst, mem_word(32'h8)); end
        total++; if (state_dbg !== ST_REQ) begin bad++; $display("FAIL jack_state: got %0d want %0d", state_dbg, ST_REQ); end
      end
      if (inst_valid === 1'b1) begin
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL jack_pc: got %h want %h", pc, exp_pc); end
        total++; if (inst !== mem_word(exp_pc)) begin bad++; $display("FAIL jack_inst: got %h want %h", inst, mem_word(exp_pc)); end
        if (exp_pc == 32'h200) done = 1'b1;
        if (exp_pc == 32'h8 && !redirected) begin
          total++; if (imem_ce !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL jack_same_cycle: ce %b addr %h want 1 c", imem_ce, imem_addr); end
          jCe = 1'b1; jAddr = 32'h0000_0203;
          redirected = 1'b1; rc = c;
          exp_pc = 32'h200;
        end else begin
          exp_pc += 32'd4;
        end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL jack_reach_target: got %b want 1", done); end
  endtask

  task automatic test_reset_midreq();
    bit done;
    mem_lat = 3; mem_rand = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    mem_wait = 0;
    mem_lat_cur = 3;
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL late_ack_pushed: valid %b want 0", inst_valid); end
    total++; if (imem_ce !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL late_ack_req: ce %b addr %h want 1 0", imem_ce, imem_addr); end
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (inst_valid === 1'b1) begin
        done = 1'b1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL late_ack_pc: got %h want 0", pc); end
        total++; if (inst !== mem_word(32'h0)) begin bad++; $display("FAIL late_ack_inst: got %h want %h", inst, mem_word(32'h0)); end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL late_ack_timeout: got %b want 1", done); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp2;
    int got;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset();
    exp2 = 32'hFFFF_FFF8;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      tick();
      if (valid2 === 1'b1) begin
        total++; if (pc2 !== exp2) begin bad++; $display("FAIL wrap_pc: got %h want %h", pc2, exp2); end
        total++; if (inst2 !== mem_word(exp2)) begin bad++; $display("FAIL wrap_inst: got %h want %h", inst2, mem_word(exp2)); end
        exp2 += 32'd4;
        got++;
      end
    end
    total++; if (got != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", got); end
  endtask

  task automatic test_random();
    int accepts;
    bit prev_pending;
    logic [31:0] prev_addr;
    mem_lat = 0; mem_rand = 1'b1;
    do_reset();
    exp_pc = 32'h0;
    accepts = 0;
    prev_pending = 1'b0;
    prev_addr = '0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (prev_pending) begin
        total++;
        if (imem_ce !== 1'b1 || imem_addr !== prev_addr) begin
          bad++; $display("FAIL rand_req_hold: ce %b addr %h want 1 %h", imem_ce, imem_addr, prev_addr);
        end
      end
      total++; if (imem_addr[1:0] !== 2'b00) begin bad++; $display("FAIL rand_addr_align: got %h", imem_addr); end
      prev_pending = (imem_ce === 1'b1) && !imem_ack;
      prev_addr = imem_addr;
      inst_ready = ($urandom_range(0, 9) < 7);
      jCe = 1'b0;
      if (inst_valid === 1'b1 && inst_ready) begin
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL rand_pc: got %h want %h", pc, exp_pc); end
        total++; if (inst !== mem_word(exp_pc)) begin bad++; $display("FAIL rand_inst: got %h want %h", inst, mem_word(exp_pc)); end
        accepts++;
        if ($urandom_range(0, 9) == 0) begin
          jCe = 1'b1;
          jAddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
          exp_pc = {jAddr[31:2], 2'b00};
        end else begin
          exp_pc += 32'd4;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        jCe = 1'b1;
        jAddr = $urandom;
      end
    end
    total++; if (accepts < 200) begin bad++; $display("FAIL rand_progress: got %0d accepts want >= 200", accepts); end
    inst_ready = 1'b0;
    jCe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_reset_midreq();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
